// File: rtl/traffic_pkg.sv
// Light codes and debounce FSM encoding shared by the country-road detector
// and the highway/country signal controller.
package traffic_pkg;

  localparam logic [1:0] RED     = 2'd0;
  localparam logic [1:0] YELLOW  = 2'd1;
  localparam logic [1:0] GREEN   = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StQualOn  = 2'd1,
    StPresent = 2'd2,
    StQualOff = 2'd3
  } db_state_e;

  // Country traffic may legally clear the stop line on green or yellow.
  function automatic logic light_allows_exit(input logic [1:0] light);
    return (light == GREEN) || (light == YELLOW);
  endfunction

endpackage

// File: rtl/country_car_detector_if.sv
// Sensor/controller-facing signals of the country-road car detector.
// master drives the sensors and light code; slave is the detector itself.
interface country_car_detector_if #(
  parameter int unsigned QUEUE_W = 4
);

  logic               loop_raw;
  logic               exit_pulse;
  logic [1:0]         cntry;
  logic               x;
  logic [QUEUE_W-1:0] queue_count;
  logic               queue_full;
  logic               red_run;
  logic               illegal_light;

  modport master (
    output loop_raw, exit_pulse, cntry,
    input  x, queue_count, queue_full, red_run, illegal_light
  );

  modport slave (
    input  loop_raw, exit_pulse, cntry,
    output x, queue_count, queue_full, red_run, illegal_light
  );

endinterface

// File: rtl/loop_debounce.sv
// Two-flop synchroniser plus debounce FSM for the inductive loop; emits one
// arrive strobe per vehicle that stays over the loop long enough.
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear_n,
  input  logic loop_raw,
  output logic arrive
);

  localparam logic [3:0] Target = 4'(DEBOUNCE_CYCLES);

  logic      sync1_q;
  logic      loop_s_q;
  db_state_e state_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync1_q  <= 1'b0;
      loop_s_q <= 1'b0;
    end else begin
      sync1_q  <= loop_raw;
      loop_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (loop_s_q) begin
            state_q <= StQualOn;
            cnt_q   <= 4'd1;
          end
        end
        StQualOn: begin
          if (!loop_s_q) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else if (cnt_inc == Target) begin
            state_q <= StPresent;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StPresent: begin
          if (!loop_s_q) begin
            state_q <= StQualOff;
            cnt_q   <= 4'd1;
          end
        end
        StQualOff: begin
          // A return of metal inside the window is the same vehicle, not a new one.
          if (loop_s_q) begin
            state_q <= StPresent;
            cnt_q   <= 4'd0;
          end else if (cnt_inc == Target) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Asserted during the cycle whose closing edge moves QUAL_ON to PRESENT,
  // so the queue counts the vehicle on that same edge.
  assign arrive = (state_q == StQualOn) && loop_s_q && (cnt_inc == Target);

endmodule

// File: rtl/country_car_detector.sv
// Country-road vehicle queue: counts debounced arrivals and legal departures,
// requests right-of-way via x, and flags red-light runs and bad light codes.
module country_car_detector
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned QUEUE_W         = 4
) (
  input logic                   clock,
  input logic                   clear_n,
  country_car_detector_if.slave bus
);

  localparam logic [QUEUE_W-1:0] QMax = '1;
  localparam logic [QUEUE_W-1:0] QOne = QUEUE_W'(1);

  logic               arrive;
  logic               depart;
  logic [QUEUE_W-1:0] count_q;
  logic [QUEUE_W-1:0] count_d;
  logic               red_run_q;
  logic               illegal_q;

  loop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_loop_debounce (
    .clock   (clock),
    .clear_n (clear_n),
    .loop_raw(bus.loop_raw),
    .arrive  (arrive)
  );

  assign depart = bus.exit_pulse && light_allows_exit(bus.cntry);

  // Simultaneous arrive and depart cancel, even at the full and empty limits.
  always_comb begin
    count_d = count_q;
    if (arrive && !depart && (count_q != QMax)) begin
      count_d = count_q + QOne;
    end else if (depart && !arrive && (count_q != '0)) begin
      count_d = count_q - QOne;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q   <= '0;
      red_run_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      red_run_q <= bus.exit_pulse && (bus.cntry == RED);
      illegal_q <= (bus.cntry == ILLEGAL);
    end
  end

  assign bus.x             = (count_q != '0);
  assign bus.queue_count   = count_q;
  assign bus.queue_full    = (count_q == QMax);
  assign bus.red_run       = red_run_q;
  assign bus.illegal_light = illegal_q;

endmodule

// File: tb/tb_country_car_detector.sv
// Directed bench for country_car_detector: expected outputs are queued as
// stimulus is applied and popped for comparison once the DUT has responded.
module tb_country_car_detector;
  import traffic_pkg::*;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  always #5 clock = ~clock;

  country_car_detector_if #(.QUEUE_W(4)) bus ();

  country_car_detector #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_W        (4)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] qc;
    logic       rr;
    logic       il;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_out(input string tag, input int qc, input logic rr, input logic il);
    exp_t e;
    e.tag = tag;
    e.qc  = 4'(qc);
    e.rr  = rr;
    e.il  = il;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $display("FAIL %s.%s got=%0d want=%0d", tag, field, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=0 entries want>=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "queue_count", bus.queue_count, e.qc);
    cmp(e.tag, "x", 4'(bus.x), 4'(e.qc != 4'd0));
    cmp(e.tag, "queue_full", 4'(bus.queue_full), 4'(e.qc == 4'd15));
    cmp(e.tag, "red_run", 4'(bus.red_run), 4'(e.rr));
    cmp(e.tag, "illegal_light", 4'(bus.illegal_light), 4'(e.il));
  endtask

  // Vehicle dwells well past the debounce window, then leaves long enough to re-arm.
  task automatic vehicle();
    bus.loop_raw = 1'b1;
    tick(8);
    bus.loop_raw = 1'b0;
    tick(8);
  endtask

  task automatic exit_step(input string tag, input int qc, input logic rr, input logic il);
    expect_out(tag, qc, rr, il);
    bus.exit_pulse = 1'b1;
    tick(1);
    bus.exit_pulse = 1'b0;
    check_out();
  endtask

  initial begin
    bus.loop_raw   = 1'b0;
    bus.exit_pulse = 1'b0;
    bus.cntry      = RED;
    clear_n        = 1'b0;
    tick(2);
    expect_out("reset", 0, 0, 0);
    check_out();
    clear_n = 1'b1;
    tick(2);

    // 1: arrival latency, counted on edge 6, no re-count while held
    bus.loop_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      expect_out($sformatf("t1_edge%0d", i), 0, 0, 0);
      tick(1);
      check_out();
    end
    expect_out("t1_edge6", 1, 0, 0);
    tick(1);
    check_out();
    expect_out("t1_hold", 1, 0, 0);
    tick(10);
    check_out();
    bus.loop_raw = 1'b0;
    tick(8);

    // 2: short pulse ignored; short dropout inside a presence stays one vehicle
    expect_out("t2_glitch", 1, 0, 0);
    bus.loop_raw = 1'b1;
    tick(3);
    bus.loop_raw = 1'b0;
    tick(8);
    check_out();
    expect_out("t2_dropout", 2, 0, 0);
    bus.loop_raw = 1'b1;
    tick(8);
    bus.loop_raw = 1'b0;
    tick(2);
    bus.loop_raw = 1'b1;
    tick(8);
    bus.loop_raw = 1'b0;
    tick(8);
    check_out();

    // 3: departures on green, no underflow
    bus.cntry = GREEN;
    exit_step("t3_drain1", 1, 0, 0);
    exit_step("t3_drain0", 0, 0, 0);
    expect_out("t3_three", 3, 0, 0);
    vehicle();
    vehicle();
    vehicle();
    check_out();
    exit_step("t3_exit2", 2, 0, 0);
    exit_step("t3_exit1", 1, 0, 0);
    exit_step("t3_exit0", 0, 0, 0);
    exit_step("t3_underflow", 0, 0, 0);

    // 4: red run blocks departure and pulses one cycle; yellow departs
    expect_out("t4_two", 2, 0, 0);
    vehicle();
    vehicle();
    check_out();
    bus.cntry = RED;
    exit_step("t4_red", 2, 1, 0);
    expect_out("t4_red_end", 2, 0, 0);
    tick(1);
    check_out();
    bus.cntry = YELLOW;
    exit_step("t4_yellow", 1, 0, 0);

    // 5: saturation, same-edge arrive/depart at full, illegal light code
    for (int i = 2; i <= 15; i++) begin
      expect_out($sformatf("t5_fill%0d", i), i, 0, 0);
      vehicle();
      check_out();
    end
    expect_out("t5_sat", 15, 0, 0);
    vehicle();
    check_out();
    bus.cntry    = GREEN;
    bus.loop_raw = 1'b1;
    tick(5);
    exit_step("t5_same_edge", 15, 0, 0);
    bus.loop_raw = 1'b0;
    tick(8);
    bus.cntry = ILLEGAL;
    exit_step("t5_illegal", 15, 0, 1);
    bus.cntry = GREEN;
    expect_out("t5_legal", 15, 0, 0);
    tick(1);
    check_out();

    // 6: asynchronous clear mid-qualification
    for (int i = 14; i >= 5; i--) begin
      exit_step($sformatf("t6_drain%0d", i), i, 0, 0);
    end
    bus.loop_raw = 1'b1;
    tick(4);
    #2 clear_n = 1'b0;
    #1;
    expect_out("t6_async_clear", 0, 0, 0);
    check_out();
    tick(2);
    expect_out("t6_held_clear", 0, 0, 0);
    check_out();
    bus.loop_raw = 1'b0;
    clear_n      = 1'b1;
    tick(2);
    expect_out("t6_after", 1, 0, 0);
    vehicle();
    check_out();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d entries want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/country_car_detector.md
Name: country_car_detector

Overview:
- Produces the `x` car-waiting request consumed by the highway/country signal controller, and reads back that controller's `cntry` light code.
- Synchronises and debounces the raw country-road inductive loop and counts vehicle arrivals.
- Counts departures through the intersection, taken only while country has right-of-way.
- Holds `x` asserted while any vehicle is queued; flags red-light runs and illegal light codes.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to accept a loop edge (range 2..15).
- QUEUE_W, 4: width of the vehicle queue counter; saturates at 2^QUEUE_W-1.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- loop_raw  in  1  raw loop sensor, asynchronous to clock, high = metal over loop
- exit_pulse  in  1  synchronous one-cycle pulse: a vehicle crossed the country stop line
- cntry  in  2  country light code from the controller: 0 RED, 1 YELLOW, 2 GREEN, 3 illegal
- x  out  1  request to the controller: high while queue_count != 0
- queue_count  out  QUEUE_W  vehicles currently waiting
- queue_full  out  1  queue_count == 2^QUEUE_W-1
- red_run  out  1  one-cycle pulse: exit_pulse seen while cntry == RED
- illegal_light  out  1  registered flag: cntry == 3 sampled on the previous edge

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - clear_n low forces x=0, queue_count=0, queue_full=0, red_run=0, illegal_light=0.
  - It also clears both synchroniser flops, the debounce counter, and the FSM to IDLE.
  - Assertion mid-operation discards any partially qualified edge immediately.
- Synchroniser: two flops on loop_raw produce loop_s. There is no other use of loop_raw.
- Debounce FSM, states IDLE, QUAL_ON, PRESENT, QUAL_OFF, with a 4-bit counter cnt:
  - IDLE: loop_s=1 → QUAL_ON, cnt=1.
  - QUAL_ON: loop_s=0 → IDLE, cnt=0. Otherwise cnt+1. When cnt reaches DEBOUNCE_CYCLES → PRESENT and arrive=1 on that edge.
  - PRESENT: loop_s=0 → QUAL_OFF, cnt=1.
  - QUAL_OFF: loop_s=1 → PRESENT (no new arrival). Otherwise cnt+1. When cnt reaches DEBOUNCE_CYCLES → IDLE.
  - Exactly one arrival per accepted vehicle. Glitches shorter than DEBOUNCE_CYCLES samples produce no arrival.
- Latency: count the first edge sampling loop_raw=1 as edge 1. queue_count and x update at edge DEBOUNCE_CYCLES+2 (edge 6 at the default).
- Departure qualification: depart = exit_pulse && (cntry == GREEN || cntry == YELLOW).
  - exit_pulse while cntry == RED: no decrement; red_run pulses high for the following cycle.
  - exit_pulse while cntry == 3: ignored entirely.
- Queue update, registered:
  - arrive only: +1, except at full, where it holds.
  - depart only: -1, except at 0, where it holds (no underflow).
  - arrive and depart on the same edge: unchanged, including at full and at 0.
- Derived outputs:
  - x = (queue_count != 0), derived from the register with no extra delay.
  - queue_full = (queue_count == max).
- illegal_light: registered from cntry every edge. It does not alter queue state other than blocking departures.

Decomposition:
- Shared package traffic_pkg: light codes RED=2'd0, YELLOW=2'd1, GREEN=2'd2, and the debounce FSM state encoding (2-bit).
  - The signal controller uses the same light constants.
- Sub-module loop_debounce holds the 2-flop synchroniser, the FSM and cnt.
  - Ports: clock, clear_n, loop_raw, arrive.
  - The top level holds the queue counter and the departure/flag logic.

Test Plan:
1. Reset then loop_raw=1 held, cntry=RED → x=0 through edge 5, x=1 and queue_count=1 after edge 6; no further increment while held.
2. loop_raw pulses high for 3 cycles, then a 2-cycle low dropout inside a long presence → zero arrivals from the short pulse, one arrival total for the presence.
3. Three debounced vehicles, cntry=GREEN, three exit_pulses → queue_count 3→2→1→0, x falls the edge after the third exit; a fourth exit_pulse keeps the count at 0.
4. Queue at 2, cntry=RED, exit_pulse → queue_count stays 2, red_run=1 for exactly one cycle; cntry=YELLOW, exit_pulse → queue_count=1.
5. Fill to 15 with QUEUE_W=4 → queue_full=1, a further arrival holds 15; arrival and depart on the same edge at 15 → stays 15; cntry=3 → illegal_light=1 the next cycle and exit_pulse is ignored.
6. clear_n dropped asynchronously mid-QUAL_ON with queue_count=5 → all outputs 0 immediately without a clock edge; after release, the next accepted vehicle gives queue_count=1.
